// File: rtl/mat_addr_seq_if.sv
// Candidate handshake and bank write/readout bundle
// for the matching address sequencer.
interface mat_addr_seq_if #(
  parameter int ADDR_W = 15,
  parameter int SLOT_W = 4
);
  logic              start;
  logic              featValid;
  logic [ADDR_W-1:0] featAddr;
  logic              featReady;
  logic              frameEnd;
  logic              wrEn;
  logic [SLOT_W-1:0] wrSlot;
  logic [ADDR_W-1:0] wrAddr;
  logic              posReaden;
  logic [SLOT_W:0]   matchCount;
  logic              readAck;
  logic              busy;
  logic              overflow;

  modport master (
    input  start, featValid, featAddr,
    input  frameEnd, readAck,
    output featReady, wrEn, wrSlot, wrAddr,
    output posReaden, matchCount, busy,
    output overflow
  );

  modport slave (
    output start, featValid, featAddr,
    output frameEnd, readAck,
    input  featReady, wrEn, wrSlot, wrAddr,
    input  posReaden, matchCount, busy,
    input  overflow
  );
endinterface

// File: rtl/mat_addr_seq.sv
// Assigns per-frame feature-point addresses to
// bank slots, then requests matching until acked.
module mat_addr_seq #(
  parameter int ADDR_W = 15,
  parameter int SLOTS  = 16,
  parameter int SLOT_W = 4
) (
  input logic           clk,
  input logic           rst,
  mat_addr_seq_if.master bus
);
  typedef enum logic [2:0] {
    IDLE, COLLECT, DRAIN, REPORT, SKIP
  } state_t;

  localparam logic [SLOT_W:0] LAST =
    (SLOT_W+1)'(SLOTS - 1);

  state_t            state, stateNext;
  logic [SLOT_W:0]   count, countNext;
  logic              frameDone, frameDoneNext;
  logic              ovf, ovfNext;
  logic              wrEn, wrEnNext;
  logic [SLOT_W-1:0] wrSlot, wrSlotNext;
  logic [ADDR_W-1:0] wrAddr, wrAddrNext;
  logic              ready;
  logic              accept;

  assign ready  = (state == COLLECT) ||
                  (state == SKIP);
  assign accept = bus.featValid & ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      frameDone <= 1'b0;
      ovf       <= 1'b0;
      wrEn      <= 1'b0;
      wrSlot    <= '0;
      wrAddr    <= '0;
    end else begin
      state     <= stateNext;
      count     <= countNext;
      frameDone <= frameDoneNext;
      ovf       <= ovfNext;
      wrEn      <= wrEnNext;
      wrSlot    <= wrSlotNext;
      wrAddr    <= wrAddrNext;
    end
  end

  always_comb begin
    stateNext     = state;
    countNext     = count;
    frameDoneNext = frameDone;
    ovfNext       = ovf;
    wrEnNext      = 1'b0;
    wrSlotNext    = wrSlot;
    wrAddrNext    = wrAddr;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          stateNext     = COLLECT;
          countNext     = '0;
          ovfNext       = 1'b0;
          frameDoneNext = 1'b0;
        end
      end
      COLLECT: begin
        if (accept) begin
          wrEnNext   = 1'b1;
          wrSlotNext = count[SLOT_W-1:0];
          wrAddrNext = bus.featAddr;
          countNext  = count + 1'b1;
        end
        // filling the bank wins over frameEnd
        if (accept && count == LAST) begin
          stateNext     = DRAIN;
          frameDoneNext = bus.frameEnd;
        end else if (bus.frameEnd &&
                     (accept || count != '0)) begin
          stateNext     = DRAIN;
          frameDoneNext = 1'b1;
        end else if (bus.frameEnd) begin
          stateNext = IDLE;
        end
      end
      DRAIN: stateNext = REPORT;
      REPORT: begin
        if (bus.readAck)
          stateNext = frameDone ? IDLE : SKIP;
      end
      SKIP: begin
        if (accept)       ovfNext   = 1'b1;
        if (bus.frameEnd) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign bus.featReady  = ready;
  assign bus.wrEn       = wrEn;
  assign bus.wrSlot     = wrSlot;
  assign bus.wrAddr     = wrAddr;
  assign bus.posReaden  = (state == REPORT);
  assign bus.matchCount =
    (state == REPORT) ? count : '0;
  assign bus.busy       = (state != IDLE);
  assign bus.overflow   = ovf;
endmodule

// File: tb/tb_mat_addr_seq.sv
// Directed vector bench for mat_addr_seq.
module tb_mat_addr_seq;
  localparam int ADDR_W = 15;
  localparam int SLOT_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mat_addr_seq_if #(
    .ADDR_W(ADDR_W), .SLOT_W(SLOT_W)
  ) bus ();

  mat_addr_seq #(
    .ADDR_W(ADDR_W), .SLOTS(16), .SLOT_W(SLOT_W)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    logic              st, fv, fe, ack;
    logic [ADDR_W-1:0] addr;
    logic              eRdy, eWr, ePos, eBusy, eOvf;
    logic [SLOT_W-1:0] eSlot;
    logic [ADDR_W-1:0] eAddr;
    logic [SLOT_W:0]   eCnt;
  } vec_t;

  int nRun  = 0;
  int nFail = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nRun++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    int st, int fv, int addr, int fe, int ack,
    int rdy, int wr, int slot, int waddr,
    int pos, int cnt, int bsy, int ovf);
    vec_t v;
    v.st    = st[0];
    v.fv    = fv[0];
    v.addr  = addr[ADDR_W-1:0];
    v.fe    = fe[0];
    v.ack   = ack[0];
    v.eRdy  = rdy[0];
    v.eWr   = wr[0];
    v.eSlot = slot[SLOT_W-1:0];
    v.eAddr = waddr[ADDR_W-1:0];
    v.ePos  = pos[0];
    v.eCnt  = cnt[SLOT_W:0];
    v.eBusy = bsy[0];
    v.eOvf  = ovf[0];
    return v;
  endfunction

  task automatic drive(int st, int fv, int addr,
                       int fe, int ack);
    bus.start     = st[0];
    bus.featValid = fv[0];
    bus.featAddr  = addr[ADDR_W-1:0];
    bus.frameEnd  = fe[0];
    bus.readAck   = ack[0];
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  vec_t tbl[$];

  initial begin
    // short frame, abuse inputs, empty frame
    tbl.push_back(mk(1,0,0,0,0,   1,0,0,0,0,0,1,0));
    tbl.push_back(mk(0,1,'h100,0,0,
                     1,1,0,'h100,0,0,1,0));
    tbl.push_back(mk(0,1,'h101,0,1,
                     1,1,1,'h101,0,0,1,0));
    tbl.push_back(mk(0,1,'h102,0,0,
                     1,1,2,'h102,0,0,1,0));
    tbl.push_back(mk(0,1,'h103,0,0,
                     1,1,3,'h103,0,0,1,0));
    tbl.push_back(mk(0,1,'h104,1,0,
                     0,1,4,'h104,0,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,   0,0,0,0,1,5,1,0));
    tbl.push_back(mk(1,0,0,0,0,   0,0,0,0,1,5,1,0));
    tbl.push_back(mk(0,0,0,0,1,   0,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,   1,0,0,0,0,0,1,0));
    tbl.push_back(mk(0,0,0,1,0,   0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,'h55,1,1,
                     0,0,0,0,0,0,0,0));

    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    #1;
    chk("rst featReady", bus.featReady, 0);
    chk("rst wrEn", bus.wrEn, 0);
    chk("rst wrSlot", bus.wrSlot, 0);
    chk("rst wrAddr", bus.wrAddr, 0);
    chk("rst posReaden", bus.posReaden, 0);
    chk("rst matchCount", bus.matchCount, 0);
    chk("rst busy", bus.busy, 0);
    chk("rst overflow", bus.overflow, 0);
    step();
    step();
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].st, tbl[i].fv, tbl[i].addr,
            tbl[i].fe, tbl[i].ack);
      step();
      chk($sformatf("v%0d featReady", i),
          bus.featReady, tbl[i].eRdy);
      chk($sformatf("v%0d wrEn", i),
          bus.wrEn, tbl[i].eWr);
      if (tbl[i].eWr) begin
        chk($sformatf("v%0d wrSlot", i),
            bus.wrSlot, tbl[i].eSlot);
        chk($sformatf("v%0d wrAddr", i),
            bus.wrAddr, tbl[i].eAddr);
      end
      chk($sformatf("v%0d posReaden", i),
          bus.posReaden, tbl[i].ePos);
      chk($sformatf("v%0d matchCount", i),
          bus.matchCount, tbl[i].eCnt);
      chk($sformatf("v%0d busy", i),
          bus.busy, tbl[i].eBusy);
      chk($sformatf("v%0d overflow", i),
          bus.overflow, tbl[i].eOvf);
    end

    // exact fill, frameEnd with the 16th
    drive(1, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 'h200 + i, (i == 15) ? 1 : 0, 0);
      step();
      chk($sformatf("fill wrEn %0d", i), bus.wrEn, 1);
      chk($sformatf("fill wrSlot %0d", i),
          bus.wrSlot, i);
      chk($sformatf("fill wrAddr %0d", i),
          bus.wrAddr, 'h200 + i);
    end
    chk("fill drain featReady", bus.featReady, 0);
    chk("fill drain posReaden", bus.posReaden, 0);
    drive(0, 1, 'h7fff, 0, 0);
    step();
    chk("fill drain nowrite", bus.wrEn, 0);
    chk("fill posReaden", bus.posReaden, 1);
    chk("fill matchCount", bus.matchCount, 16);
    chk("fill overflow", bus.overflow, 0);
    drive(0, 0, 0, 0, 1);
    step();
    chk("fill idle busy", bus.busy, 0);
    chk("fill no skip", bus.featReady, 0);
    chk("fill posReaden off", bus.posReaden, 0);

    // overflow: 20 candidates
    drive(1, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 'h300 + i, 0, 0);
      step();
      chk($sformatf("ovf wrSlot %0d", i),
          bus.wrSlot, i);
    end
    chk("ovf featReady drop", bus.featReady, 0);
    drive(0, 1, 'h310, 0, 0);
    step();
    chk("ovf posReaden", bus.posReaden, 1);
    chk("ovf matchCount", bus.matchCount, 16);
    chk("ovf report nowrite", bus.wrEn, 0);
    drive(0, 1, 'h310, 0, 1);
    step();
    chk("ovf skip featReady", bus.featReady, 1);
    chk("ovf skip posReaden", bus.posReaden, 0);
    chk("ovf before skip", bus.overflow, 0);
    for (int j = 0; j < 4; j++) begin
      drive(0, 1, 'h310 + j, (j == 3) ? 1 : 0, 0);
      step();
      chk($sformatf("ovf skip wrEn %0d", j),
          bus.wrEn, 0);
      chk($sformatf("ovf flag %0d", j),
          bus.overflow, 1);
    end
    chk("ovf idle busy", bus.busy, 0);
    drive(0, 0, 0, 0, 0);
    step();
    chk("ovf sticky", bus.overflow, 1);
    drive(1, 0, 0, 0, 0);
    step();
    chk("ovf cleared by start", bus.overflow, 0);
    chk("restart featReady", bus.featReady, 1);

    // reset mid-collect after 3 accepts
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 'h400 + i, 0, 0);
      step();
    end
    chk("pre-rst wrSlot", bus.wrSlot, 2);
    rst = 1'b1;
    #1;
    chk("mid rst wrEn", bus.wrEn, 0);
    chk("mid rst wrSlot", bus.wrSlot, 0);
    chk("mid rst wrAddr", bus.wrAddr, 0);
    chk("mid rst featReady", bus.featReady, 0);
    chk("mid rst busy", bus.busy, 0);
    drive(0, 1, 'h410, 1, 1);
    for (int k = 0; k < 2; k++) begin
      step();
      chk($sformatf("rst hold wrEn %0d", k),
          bus.wrEn, 0);
      chk($sformatf("rst hold pos %0d", k),
          bus.posReaden, 0);
    end
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    step();
    chk("post rst busy", bus.busy, 0);
    chk("post rst posReaden", bus.posReaden, 0);

    $display("[TB] %0d tests run, %0d failed",
             nRun, nFail);
    $finish;
  end
endmodule
